// File: rtl/fib_next_ctrl_if.sv
// Handshake/term bundle between the Fibonacci next-term controller and its environment.
// master = environment (start/hold, term register outputs); slave = fib_next_ctrl.
interface fib_next_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             hold;
  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic [WIDTH-1:0] term_out;
  logic             term_valid;
  logic [WIDTH-1:0] term_idx;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, hold, cur_a, cur_b,
    input  next_a, next_b, term_out, term_valid, term_idx, busy, done, overflow
  );

  modport slave (
    input  start, hold, cur_a, cur_b,
    output next_a, next_b, term_out, term_valid, term_idx, busy, done, overflow
  );
endinterface

// File: rtl/fib_next_ctrl.sv
// Next-term controller for the Fibonacci generator: seeds, advances and ends a run of terms.
// Define FIB_WRAP_EN to let a carry-out wrap modulo 2^WIDTH instead of ending the run.
module fib_next_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_TERMS = 16
) (
  input logic           clk,
  input logic           reset,
  fib_next_ctrl_if.slave bus
);

  localparam int TERM_SPAN = 1 << WIDTH;
  localparam int MAX_EFF   = (MAX_TERMS < 1) ? 1 :
                             ((MAX_TERMS > TERM_SPAN) ? TERM_SPAN : MAX_TERMS);
  localparam logic [WIDTH:0] MAX_CNT = (WIDTH+1)'(MAX_EFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] term_out_q, term_out_d;
  logic             term_valid_q, term_valid_d;
  logic [WIDTH-1:0] term_idx_q, term_idx_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   emit_cnt_q, emit_cnt_d;

  logic [WIDTH-1:0] next_a, next_b;
  logic             busy, done;

  // Emit counter is one bit wider than term_idx so MAX_TERMS = 2^WIDTH is reachable.
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH:0]   cnt_inc;
  logic             last_emit;
  logic             cnt_full;

  assign sum       = {1'b0, bus.cur_a} + {1'b0, bus.cur_b};
  assign carry     = sum[WIDTH];
  assign cnt_inc   = emit_cnt_q + (WIDTH+1)'(1);
  assign last_emit = (cnt_inc == MAX_CNT);
  assign cnt_full  = (emit_cnt_q == MAX_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      term_out_q   <= '0;
      term_valid_q <= 1'b0;
      term_idx_q   <= '0;
      overflow_q   <= 1'b0;
      emit_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      term_out_q   <= term_out_d;
      term_valid_q <= term_valid_d;
      term_idx_q   <= term_idx_d;
      overflow_q   <= overflow_d;
      emit_cnt_q   <= emit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_LOAD;
      S_LOAD:         state_d = S_RUN;
      S_RUN: begin
        if (!bus.hold) begin
          if (last_emit) begin
            state_d = S_DONE;
          end else if (carry) begin
`ifdef FIB_WRAP_EN
            state_d = S_RUN;
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
      S_DRAIN:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    next_a       = bus.cur_a;
    next_b       = bus.cur_b;
    term_out_d   = term_out_q;
    term_valid_d = 1'b0;
    term_idx_d   = term_idx_q;
    overflow_d   = overflow_q;
    emit_cnt_d   = emit_cnt_q;
    busy         = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done         = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          term_idx_d = '0;
          overflow_d = 1'b0;
          emit_cnt_d = '0;
        end
      end
      S_LOAD: begin
        next_a = '0;
        next_b = WIDTH'(1);
      end
      S_RUN: begin
        if (!bus.hold) begin
          term_out_d   = bus.cur_a;
          term_valid_d = 1'b1;
          term_idx_d   = emit_cnt_q[WIDTH-1:0];
          emit_cnt_d   = cnt_inc;
          // The term limit wins over carry: registers freeze and overflow stays untouched.
          if (!last_emit) begin
            if (carry) begin
              overflow_d = 1'b1;
`ifdef FIB_WRAP_EN
              next_a = bus.cur_b;
              next_b = sum[WIDTH-1:0];
`endif
            end else begin
              next_a = bus.cur_b;
              next_b = sum[WIDTH-1:0];
            end
          end
        end
      end
      S_DRAIN: begin
        if (!cnt_full) begin
          term_out_d   = bus.cur_b;
          term_valid_d = 1'b1;
          term_idx_d   = emit_cnt_q[WIDTH-1:0];
          emit_cnt_d   = cnt_inc;
        end
      end
      default: begin
        next_a = bus.cur_a;
        next_b = bus.cur_b;
      end
    endcase
  end

  assign bus.next_a     = next_a;
  assign bus.next_b     = next_b;
  assign bus.term_out   = term_out_q;
  assign bus.term_valid = term_valid_q;
  assign bus.term_idx   = term_idx_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.overflow   = overflow_q;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(busy && done));
  a_valid_needs_run: assert property (@(posedge clk) disable iff (reset)
                                      term_valid_q |-> (busy || done));

endmodule

// File: tb/tb_fib_next_ctrl.sv
// Bench for fib_next_ctrl: three instances (MAX_TERMS 16, 5, 7) share start/hold/reset and
// are checked against a plain-arithmetic Fibonacci model of each run.
module tb_fib_next_ctrl;
  localparam int W    = 4;
  localparam int N    = 3;
  localparam int SPAN = 1 << W;

`ifdef FIB_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, hold;
  always #5 clk = ~clk;

  logic [W-1:0] tout [N];
  logic [W-1:0] tidx [N];
  logic         tval [N];
  logic         tbusy[N];
  logic         tdone[N];
  logic         tovf [N];

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int MT = (g == 0) ? 16 : ((g == 1) ? 5 : 7);
    fib_next_ctrl_if #(.WIDTH(W)) bus ();
    logic [W-1:0] reg_a, reg_b;

    // Term registers A and B, loading reg_in every clock.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        reg_a <= '0;
        reg_b <= '0;
      end else begin
        reg_a <= bus.next_a;
        reg_b <= bus.next_b;
      end
    end

    assign bus.start = start;
    assign bus.hold  = hold;
    assign bus.cur_a = reg_a;
    assign bus.cur_b = reg_b;
    assign tout[g]   = bus.term_out;
    assign tidx[g]   = bus.term_idx;
    assign tval[g]   = bus.term_valid;
    assign tbusy[g]  = bus.busy;
    assign tdone[g]  = bus.done;
    assign tovf[g]   = bus.overflow;

    fib_next_ctrl #(.WIDTH(W), .MAX_TERMS(MT)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );
  end

  function automatic int mt(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 5 : 7);
  endfunction

  int exp_t[N][64];
  int exp_n[N];
  bit exp_o[N];

  task automatic build_model();
    for (int i = 0; i < N; i++) begin
      int a, b, s, n;
      bit ovf, fin;
      a = 0; b = 1; n = 0; ovf = 1'b0; fin = 1'b0;
      while (!fin) begin
        exp_t[i][n] = a;
        n++;
        if (n == mt(i)) begin
          fin = 1'b1;
        end else begin
          s = a + b;
          if (s >= SPAN) begin
            ovf = 1'b1;
            if (!WRAP) begin
              exp_t[i][n] = b;
              n++;
              fin = 1'b1;
            end
          end
          if (!fin) begin
            a = b;
            b = s % SPAN;
          end
        end
      end
      exp_n[i] = n;
      exp_o[i] = ovf;
    end
  endtask

  int cap_t[N][256];
  int cap_i[N][256];
  int cap_n[N] = '{0, 0, 0};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (tval[i] === 1'b1) begin
        cap_t[i][cap_n[i] % 256] = int'(tout[i]);
        cap_i[i][cap_n[i] % 256] = int'(tidx[i]);
        cap_n[i]++;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int base[N];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mark();
    for (int i = 0; i < N; i++) base[i] = cap_n[i];
  endtask

  function automatic bit all_done();
    return tdone[0] && tdone[1] && tdone[2];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c = 0;
    while (!all_done() && c < budget) begin
      step();
      c++;
    end
    checks++;
    if (!all_done()) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b%b%b after %0d cycles, required 111",
               nm, tdone[0], tdone[1], tdone[2], c);
    end
  endtask

  task automatic check_run(input string nm);
    for (int i = 0; i < N; i++) begin
      int n;
      n = cap_n[i] - base[i];
      checks++;
      if (n !== exp_n[i]) begin
        errors++;
        $display("FAIL %s_count[%0d]: got %0d terms, required %0d", nm, i, n, exp_n[i]);
      end
      for (int k = 0; k < n && k < exp_n[i]; k++) begin
        checks++;
        if (cap_t[i][(base[i] + k) % 256] !== exp_t[i][k]) begin
          errors++;
          $display("FAIL %s_term[%0d][%0d]: got %0d, required %0d", nm, i, k,
                   cap_t[i][(base[i] + k) % 256], exp_t[i][k]);
        end
        checks++;
        if (cap_i[i][(base[i] + k) % 256] !== (k % SPAN)) begin
          errors++;
          $display("FAIL %s_idx[%0d][%0d]: got %0d, required %0d", nm, i, k,
                   cap_i[i][(base[i] + k) % 256], k % SPAN);
        end
      end
      checks++;
      if (tovf[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL %s_overflow[%0d]: got %b, required %b", nm, i, tovf[i], exp_o[i]);
      end
      checks++;
      if (tdone[i] !== 1'b1 || tbusy[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s_end_state[%0d]: done=%b busy=%b, required done=1 busy=0",
                 nm, i, tdone[i], tbusy[i]);
      end
    end
  endtask

  task automatic check_cleared(input string nm);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tout[i] !== '0 || tval[i] !== 1'b0 || tidx[i] !== '0 || tovf[i] !== 1'b0 ||
          tbusy[i] !== 1'b0 || tdone[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d]: out=%0d val=%b idx=%0d ovf=%b busy=%b done=%b, required all 0",
                 nm, i, tout[i], tval[i], tidx[i], tovf[i], tbusy[i], tdone[i]);
      end
    end
  endtask

  task automatic check_started(input string nm);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tbusy[i] !== 1'b1 || tovf[i] !== 1'b0 || tdone[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s_load[%0d]: busy=%b ovf=%b done=%b, required busy=1 ovf=0 done=0",
                 nm, i, tbusy[i], tovf[i], tdone[i]);
      end
    end
  endtask

  task automatic wait_strobe0(input string nm, input int idx);
    int c = 0;
    while (!(tval[0] === 1'b1 && int'(tidx[0]) == idx) && c < 60) begin
      step();
      c++;
    end
    checks++;
    if (!(tval[0] === 1'b1 && int'(tidx[0]) == idx)) begin
      errors++;
      $display("FAIL %s_strobe_wait: no strobe with idx %0d within %0d cycles", nm, idx, c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    #1 reset = 1'b1;
    #1 check_cleared("reset_async");
    start = 1'b1;
    repeat (3) step();
    check_cleared("reset_start_ignored");
    reset = 1'b0;
    start = 1'b0;
    step();
    check_cleared("reset_release_idle");
  endtask

  task automatic test_default_run();
    mark();
    pulse_start();
    check_started("default");
    wait_done("default", 100);
    check_run("default");
  endtask

  task automatic test_hold();
    mark();
    pulse_start();
    check_started("hold");
    wait_strobe0("hold", 2);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (tval[i] !== 1'b0 || tbusy[i] !== 1'b1) begin
          errors++;
          $display("FAIL hold_quiet[%0d] cycle %0d: valid=%b busy=%b, required valid=0 busy=1",
                   i, c, tval[i], tbusy[i]);
        end
      end
    end
    hold = 1'b0;
    wait_done("hold", 100);
    check_run("hold");
  endtask

  task automatic test_reset_midrun();
    mark();
    pulse_start();
    wait_strobe0("midrun", 4);
    #3 reset = 1'b1;
    #1 check_cleared("midrun_async");
    start = 1'b1;
    step();
    step();
    check_cleared("midrun_held");
    reset = 1'b0;
    start = 1'b0;
    step();
    check_cleared("midrun_idle");
    mark();
    pulse_start();
    check_started("restart");
    wait_done("restart", 100);
    check_run("restart");
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 6; r++) begin
      int c;
      int idle;
      idle = $urandom_range(0, 4);
      for (int k = 0; k < idle; k++) begin
        hold = ($urandom_range(0, 1) == 0);
        step();
      end
      mark();
      pulse_start();
      check_started("random");
      c = 0;
      while (!all_done() && c < 300) begin
        hold  = ($urandom_range(0, 2) == 0);
        start = (tbusy[0] && tbusy[1] && tbusy[2] && $urandom_range(0, 7) == 0);
        step();
        c++;
      end
      start = 1'b0;
      hold  = 1'b0;
      checks++;
      if (!all_done()) begin
        errors++;
        $display("FAIL random_done_timeout: run %0d not done after %0d cycles", r, c);
      end
      check_run("random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    test_reset();
    test_default_run();
    test_hold();
    test_reset_midrun();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
